// File: rtl/pcileech_ft601_txbuf.sv
// Transmit-side dword buffer feeding the FT601/FT245 controller.
// Accepts one- or two-dword writes from the response path and hands dwords
// to the controller one per cycle with a fixed one-cycle pop latency.
// Storage is split into an even and an odd bank so that a two-dword write
// touches each bank exactly once. Each bank then needs only one write port
// and one synchronous read port, which maps onto simple dual-port block RAM.
module pcileech_ft601_txbuf #(
  parameter int DEPTH_LOG2   = 10,
  parameter int AFULL_MARGIN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [63:0]           wr_data,
  input  logic                  wr_en,
  input  logic                  wr_dw2,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   count,
  output logic [31:0]           din,
  output logic                  din_empty,
  input  logic                  din_req_data,
  output logic                  din_wr_en
);

  localparam int AW         = DEPTH_LOG2;
  localparam int CW         = DEPTH_LOG2 + 1;
  localparam int BANK_AW    = DEPTH_LOG2 - 1;
  localparam int BANK_DEPTH = 1 << BANK_AW;

  localparam logic [CW-1:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_MARGIN);

  logic [31:0]         bankEven [BANK_DEPTH];
  logic [31:0]         bankOdd  [BANK_DEPTH];

  logic [AW-1:0]       wrPtr_q, wrPtr_d;
  logic [AW-1:0]       rdPtr_q, rdPtr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                dinValid_q;
  logic [31:0]         dinData_q;

  logic [CW-1:0]       freeDw;
  logic                wrAccept;
  logic [1:0]          pushCnt;
  logic                popEn;

  logic [BANK_AW-1:0]  wrHalf;
  logic [BANK_AW-1:0]  rdHalf;
  logic                evenWe;
  logic [BANK_AW-1:0]  evenAddr;
  logic [31:0]         evenData;
  logic                oddWe;
  logic [BANK_AW-1:0]  oddAddr;
  logic [31:0]         oddData;

  // Admission and pop decisions, taken only from the registered count so a
  // same-cycle pop never makes room for a write.
  always_comb begin
    freeDw   = DEPTH_C - count_q;
    wrAccept = 1'b0;
    pushCnt  = 2'd0;
    if (wr_en) begin
      wrAccept = wr_dw2 ? (freeDw >= TWO_C) : (freeDw >= ONE_C);
    end
    if (wrAccept) begin
      pushCnt = wr_dw2 ? 2'd2 : 2'd1;
    end
    popEn = din_req_data && (count_q != '0);
  end

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    wrPtr_d    = wrPtr_q + AW'(pushCnt);
    rdPtr_d    = rdPtr_q + AW'(popEn);
    count_d    = count_q + CW'(pushCnt) - CW'(popEn);
    overflow_d = overflow_q | (wr_en & ~wrAccept);
  end

  // Steer dword 0 and dword 1 to the two banks depending on write pointer parity.
  always_comb begin
    wrHalf   = wrPtr_q[AW-1:1];
    evenWe   = 1'b0;
    evenAddr = wrHalf;
    evenData = wr_data[31:0];
    oddWe    = 1'b0;
    oddAddr  = wrHalf;
    oddData  = wr_data[63:32];
    if (!wrPtr_q[0]) begin
      evenWe   = wrAccept;
      evenData = wr_data[31:0];
      oddWe    = wrAccept & wr_dw2;
      oddData  = wr_data[63:32];
    end else begin
      oddWe    = wrAccept;
      oddData  = wr_data[31:0];
      evenWe   = wrAccept & wr_dw2;
      evenAddr = wrHalf + BANK_AW'(1);
      evenData = wr_data[63:32];
    end
  end

  assign rdHalf = rdPtr_q[AW-1:1];

  // Even bank write port (no reset so it stays inferable as block RAM).
  always_ff @(posedge clk) begin
    if (evenWe) begin
      bankEven[evenAddr] <= evenData;
    end
  end

  // Odd bank write port.
  always_ff @(posedge clk) begin
    if (oddWe) begin
      bankOdd[oddAddr] <= oddData;
    end
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dinValid_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dinValid_q <= popEn;
    end
  end

  // Synchronous read of the popped dword; holds its value when nothing is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dinData_q <= '0;
    end else if (popEn) begin
      dinData_q <= rdPtr_q[0] ? bankOdd[rdHalf] : bankEven[rdHalf];
    end
  end

  assign count          = count_q;
  assign din            = dinData_q;
  assign din_wr_en      = dinValid_q;
  assign overflow       = overflow_q;
  assign din_empty      = (count_q == '0);
  assign wr_full        = (freeDw < TWO_C);
  assign wr_almost_full = (freeDw <= AFULL_C);

endmodule
